// File: rtl/serializador_pkg.sv
// Shared types and defaults for the serializador block.
package serializador_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/serializador.sv
// Parallel-to-serial converter. Takes one word per valid/ready handshake,
// waits for the downstream deserializer to be free, then shifts the word out
// one bit per cycle and closes it with a one-cycle done pulse.
module serializador
  import serializador_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  busy_in,
  output logic                  data_serial_out,
  output logic                  write_serial_out,
  output logic                  done_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  accept;

  assign accept = (state == IDLE) && valid_in;

  // State register; reset wins over any accept on the same edge.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Shift register and bit counter. The counter is held at zero until
  // SHIFT is entered, so it always starts a word from bit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) shreg <= data_in;
          cnt <= '0;
        end
        WAIT_DS: cnt <= '0;
        SHIFT: begin
          // The outgoing bit always sits at the end selected by MSB_FIRST.
          shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          cnt   <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Next-state and Moore outputs; busy_in only matters before SHIFT begins.
  always_comb begin
    state_next       = state;
    ready_out        = 1'b0;
    write_serial_out = 1'b0;
    data_serial_out  = 1'b0;
    done_out         = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_next = busy_in ? WAIT_DS : SHIFT;
      end
      WAIT_DS: begin
        if (!busy_in) state_next = SHIFT;
      end
      SHIFT: begin
        write_serial_out = 1'b1;
        data_serial_out  = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
        if (cnt == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        done_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: an MSB-first and an LSB-first instance share the
// same inputs. Each scenario fills per-edge stimulus tables, plays them, and
// compares every cycle against a timeline model built from word events.
module tb_serializador;

  localparam int W    = 8;
  localparam int MAXN = 64;

  logic         clock = 1'b0;
  logic         reset, valid_in, busy_in;
  logic [W-1:0] data_in;
  logic         rdy_m, ser_m, wr_m, dn_m;
  logic         rdy_l, ser_l, wr_l, dn_l;

  // Stimulus tables: entry k is the value seen at accept-relative edge k.
  logic [MAXN-1:0] bz, vz, rz;
  logic [W-1:0]    dz    [MAXN];
  // obs[j] / exp_v[j]: outputs during cycle j, {rdy,wr,ser,dn} msb then lsb.
  logic [7:0]      obs   [MAXN];
  logic [7:0]      exp_v [MAXN];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serializador #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_m), .busy_in(busy_in), .data_serial_out(ser_m),
    .write_serial_out(wr_m), .done_out(dn_m)
  );

  serializador #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_l), .busy_in(busy_in), .data_serial_out(ser_l),
    .write_serial_out(wr_l), .done_out(dn_l)
  );

  task automatic clear_stim();
    bz = '0; vz = '0; rz = '0;
    for (int k = 0; k < MAXN; k++) dz[k] = 8'($urandom);
  endtask

  task automatic apply(input int k);
    reset    = rz[k];
    valid_in = vz[k];
    busy_in  = bz[k];
    data_in  = dz[k];
  endtask

  // Plays edges 0..n-1 and records the outputs of cycles 1..n-1.
  task automatic drive_window(input int n);
    @(posedge clock); #1;
    apply(0);
    for (int j = 1; j < n; j++) begin
      @(posedge clock); #1;
      obs[j] = {rdy_m, wr_m, ser_m, dn_m, rdy_l, wr_l, ser_l, dn_l};
      apply(j);
    end
  endtask

  // Timeline model: find each accept edge, the edge where shifting starts
  // (first edge with busy low), and any reset that truncates the word.
  task automatic model(input int n);
    int free, a, s, r, last, i;
    logic [W-1:0] w;
    logic bm, bl;
    for (int j = 0; j < MAXN; j++) exp_v[j] = 8'b1000_1000;
    free = 0;
    while (free < n) begin
      a = free;
      while (a < n && !(vz[a] && !rz[a])) a++;
      if (a >= n) break;
      w = dz[a];
      s = a;
      while (s < n && bz[s]) s++;
      r = -1;
      for (int k = a + 1; k <= s + W && k < n; k++)
        if (r < 0 && rz[k]) r = k;
      last = (r < 0) ? s + W + 1 : r;
      for (int j = a + 1; j <= last && j < n; j++) begin
        if (j >= s + 1 && j <= s + W) begin
          i  = j - s - 1;
          bm = 1'((w >> (W - 1 - i)) & 1);
          bl = 1'((w >> i) & 1);
          exp_v[j] = {1'b0, 1'b1, bm, 1'b0, 1'b0, 1'b1, bl, 1'b0};
        end else if (j == s + W + 1) begin
          exp_v[j] = 8'b0001_0001;
        end else begin
          exp_v[j] = 8'b0000_0000;
        end
      end
      free = (r < 0) ? s + W + 2 : r + 1;
    end
  endtask

  task automatic test_reset();
    clear_stim();
    rz[0] = 1'b1; rz[1] = 1'b1; vz[1] = 1'b1; dz[1] = 8'h5A;
    drive_window(8);
    model(8);
    for (int j = 1; j < 8; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL reset cycle %0d got %b expected %b", j, obs[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_word(input logic [W-1:0] w, input string name);
    clear_stim();
    vz[0] = 1'b1; dz[0] = w;
    drive_window(14);
    model(14);
    for (int j = 1; j < 14; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL %s cycle %0d got %b expected %b", name, j, obs[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_wait_ds();
    clear_stim();
    vz[0] = 1'b1; dz[0] = 8'h01;
    for (int k = 0; k < 5; k++) bz[k] = 1'b1;
    drive_window(20);
    model(20);
    for (int j = 1; j < 20; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL wait_ds cycle %0d got %b expected %b", j, obs[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    vz[0] = 1'b1; dz[0] = 8'hFF; rz[4] = 1'b1;
    drive_window(16);
    model(16);
    for (int j = 1; j < 16; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL reset_mid cycle %0d got %b expected %b", j, obs[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int k = 0; k <= 10; k++) vz[k] = 1'b1;
    dz[0] = 8'h11;
    for (int k = 1; k <= 10; k++) dz[k] = 8'h22;
    drive_window(24);
    model(24);
    for (int j = 1; j < 24; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b expected %b", j, obs[j], exp_v[j]);
      end
    end
    // Second accept lands exactly 10 cycles after the first.
    checks++;
    if (obs[10] !== 8'b1000_1000 || obs[11][6] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_spacing got c10=%b c11=%b expected c10=10001000 with write in c11",
               obs[10], obs[11]);
    end
  endtask

  task automatic test_busy_pulse();
    clear_stim();
    vz[0] = 1'b1; dz[0] = 8'($urandom);
    bz[3] = 1'b1; bz[4] = 1'b1; bz[5] = 1'b1;
    drive_window(14);
    model(14);
    for (int j = 1; j < 14; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL busy_pulse cycle %0d got %b expected %b", j, obs[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_random();
    int h;
    for (int it = 0; it < 20; it++) begin
      clear_stim();
      vz[0] = 1'b1;
      h = $urandom_range(0, 4);
      for (int k = 0; k < h; k++) bz[k] = 1'b1;
      for (int k = h + 1; k <= h + 8; k++) bz[k] = 1'($urandom);
      for (int k = 1; k <= 8; k++) vz[k] = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rz[$urandom_range(1, 12)] = 1'b1;
      drive_window(45);
      model(45);
      for (int j = 1; j < 45; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL random it %0d cycle %0d got %b expected %b", it, j, obs[j], exp_v[j]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; busy_in = 1'b0; data_in = '0;
    test_reset();
    test_word(8'hA5, "word_a5");
    test_word(8'hC3, "word_c3");
    test_wait_ds();
    test_reset_mid();
    test_back_to_back();
    test_busy_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializador.md
SERIALIZADOR -- requirements
Module: serializador

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per transferred word.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit DATA_WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  DATA_WIDTH  parallel word to transmit.
REQ-006 SHALL have port valid_in  input  1  upstream offers data_in this cycle.
REQ-007 SHALL have port ready_out  output  1  block can accept a word this cycle.
REQ-008 SHALL have port busy_in  input  1  downstream deserializer status; high = cannot start a new word.
REQ-009 SHALL have port data_serial_out  output  1  current serial bit.
REQ-010 SHALL have port write_serial_out  output  1  qualifies data_serial_out; one bit per high cycle.
REQ-011 SHALL have port done_out  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_DS, SHIFT, DONE.
REQ-013 SHALL drive ready_out high only in IDLE, combinationally from state.
REQ-014 SHALL accept a word when valid_in and ready_out are both high at a rising edge, capturing data_in into an internal shift register.
REQ-015 SHALL, on accept, move to SHIFT if busy_in is low at that edge, else to WAIT_DS.
REQ-016 SHALL remain in WAIT_DS while busy_in is high and move to SHIFT on the first edge where busy_in is low.
REQ-017 SHALL, in SHIFT, hold write_serial_out high for exactly DATA_WIDTH consecutive cycles, presenting one bit per cycle in MSB_FIRST order.
REQ-018 SHALL place the first bit on data_serial_out in the cycle immediately after accept when busy_in was low (latency 1 cycle).
REQ-019 SHALL count bits with a counter of width $clog2(DATA_WIDTH+1), cleared on entry to SHIFT, transitioning to DONE when the count reaches DATA_WIDTH-1 at an edge in SHIFT.
REQ-020 SHALL, in DONE, drive done_out high and write_serial_out low for exactly one cycle, then return to IDLE.
REQ-021 SHALL drive write_serial_out low, data_serial_out low, and done_out low in IDLE and WAIT_DS.
REQ-022 SHALL ignore busy_in once in SHIFT; a mid-word assertion does not pause or abort the word.
REQ-023 SHALL ignore valid_in and data_in outside IDLE; the captured word is unaffected by later data_in changes.
REQ-024 SHALL give minimum back-to-back spacing of DATA_WIDTH+2 cycles between accepts (accept, DATA_WIDTH shift cycles, DONE).
REQ-025 SHALL never emit a partial word except when truncated by reset.

Reset
REQ-026 SHALL, with reset high at an edge, enter IDLE, clear the shift register and bit counter, and drive ready_out=1, write_serial_out=0, data_serial_out=0, done_out=0 from the next cycle.
REQ-027 SHALL, on reset mid-SHIFT, abort the word immediately with no done_out pulse.
REQ-028 SHALL give reset priority over any simultaneous valid_in accept.

Structure
REQ-029 SHALL place the state enum type and the DATA_WIDTH default constant in shared package serializador_pkg.
REQ-030 SHALL use no sub-module; the shift register, counter, and FSM are inline.

Verification
REQ-031 SHALL cover: reset, then valid_in=1 with data_in=8'hA5, busy_in=0, MSB_FIRST=1 -> serial bits 1,0,1,0,0,1,0,1 on cycles 1..8 with write high, then done_out=1 on cycle 9, then ready_out=1 on cycle 10.
REQ-032 SHALL cover: accept data_in=8'h01 with busy_in=1 held for 5 cycles -> WAIT_DS for 5 cycles with write low, then 8 write cycles beginning on the first cycle after busy_in falls.
REQ-033 SHALL cover: MSB_FIRST=0 with data_in=8'hC3 -> bits 1,1,0,0,0,0,1,1.
REQ-034 SHALL cover: reset asserted after the 4th bit of 8'hFF -> write_serial_out=0 next cycle, no done_out, ready_out=1.
REQ-035 SHALL cover: valid_in held high with data 8'h11 then 8'h22 -> two words with accepts exactly 10 cycles apart, and data_in changed mid-word does not alter the bits sent.
REQ-036 SHALL cover: busy_in pulsed high during SHIFT -> all 8 bits sent uninterrupted.
